// File: rtl/neuron_mac_controller.sv
// Dot-product sequencer for one neuron: streams N weight/activation pairs from negedge-read
// memories into a wide accumulator, then emits a saturated Q8.8 result. Also owns weight loading.
module neuron_mac_controller #(
  parameter int N    = 28,
  parameter int AW   = 5,
  parameter int DW   = 16,
  parameter int ACCW = 40,
  parameter int FRAC = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 LOAD_START,
  input  logic                 LD_VALID,
  input  logic signed [DW-1:0] LD_DATA,
  output logic                 LD_READY,
  output logic                 LOAD_DONE,
  output logic                 BUSY,
  output logic                 DONE,
  output logic signed [DW-1:0] Y,
  output logic                 OVF,
  output logic [AW-1:0]        BRAM_ADDR,
  output logic signed [DW-1:0] BRAM_DI,
  output logic                 BRAM_EN,
  output logic                 BRAM_WE,
  input  logic signed [DW-1:0] BRAM_DO,
  output logic [AW-1:0]        X_ADDR,
  input  logic signed [DW-1:0] X_DATA
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, FINISH} state_t;

  localparam logic [AW-1:0] LAST = AW'(N - 1);
  localparam logic signed [ACCW-1:0] YMAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] YMIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  state_t                   state;
  logic [AW-1:0]            cnt;
  logic                     vld_p0;
  logic signed [2*DW-1:0]   prod_p0;
  logic signed [ACCW-1:0]   acc_p1;

  function automatic logic signed [DW-1:0] sat_q(input logic signed [ACCW-1:0] a);
    logic signed [ACCW-1:0] s;
    s = a >>> FRAC;
    if (s > YMAX)      sat_q = YMAX[DW-1:0];
    else if (s < YMIN) sat_q = YMIN[DW-1:0];
    else               sat_q = s[DW-1:0];
  endfunction

  function automatic logic sat_ovf(input logic signed [ACCW-1:0] a);
    logic signed [ACCW-1:0] s;
    s = a >>> FRAC;
    sat_ovf = (s > YMAX) || (s < YMIN);
  endfunction

  assign BRAM_ADDR = cnt;
  assign X_ADDR    = cnt;
  assign BRAM_DI   = LD_DATA;
  assign BRAM_WE   = (state == LOAD) && LD_VALID;
  assign BRAM_EN   = (state == LOAD) ? LD_VALID : vld_p0;

  // Stage p0: data for the address issued last cycle arrives after the falling edge.
  assign prod_p0 = (2*DW)'(BRAM_DO) * (2*DW)'(X_DATA);

  // Stage p1: accumulate; vld_p0 marks a read issued in the cycle just ending.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      vld_p0    <= 1'b0;
      acc_p1    <= '0;
      Y         <= '0;
      OVF       <= 1'b0;
      DONE      <= 1'b0;
      LOAD_DONE <= 1'b0;
      BUSY      <= 1'b0;
      LD_READY  <= 1'b0;
    end else begin
      DONE      <= 1'b0;
      LOAD_DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (LOAD_START) begin
            state    <= LOAD;
            cnt      <= '0;
            BUSY     <= 1'b1;
            LD_READY <= 1'b1;
          end else if (START) begin
            state  <= RUN;
            cnt    <= '0;
            acc_p1 <= '0;
            vld_p0 <= 1'b1;
            BUSY   <= 1'b1;
          end
        end
        LOAD: begin
          if (LD_VALID) begin
            if (cnt == LAST) begin
              state     <= IDLE;
              LOAD_DONE <= 1'b1;
              BUSY      <= 1'b0;
              LD_READY  <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        RUN: begin
          if (vld_p0) begin
            acc_p1 <= acc_p1 + {{(ACCW-2*DW){prod_p0[2*DW-1]}}, prod_p0};
          end
          if (cnt == LAST) begin
            vld_p0 <= 1'b0;
            state  <= FINISH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FINISH: begin
          Y     <= sat_q(acc_p1);
          OVF   <= sat_ovf(acc_p1);
          DONE  <= 1'b1;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac_controller.sv
// Bench for neuron_mac_controller: negedge-read memory models, a dot-product reference model
// and a DONE-driven scoreboard that checks result, overflow flag and latency.
module tb_neuron_mac_controller;

  localparam int N = 28;

  logic        clk, rst, start, load_start, ld_valid;
  logic [15:0] ld_data;
  logic        ld_ready, load_done, busy, done, ovf;
  logic [15:0] y, bram_di, bram_do, x_data;
  logic [4:0]  bram_addr, x_addr;
  logic        bram_en, bram_we;

  neuron_mac_controller dut (
    .CLK(clk), .RST(rst), .START(start), .LOAD_START(load_start),
    .LD_VALID(ld_valid), .LD_DATA(ld_data), .LD_READY(ld_ready), .LOAD_DONE(load_done),
    .BUSY(busy), .DONE(done), .Y(y), .OVF(ovf),
    .BRAM_ADDR(bram_addr), .BRAM_DI(bram_di), .BRAM_EN(bram_en), .BRAM_WE(bram_we),
    .BRAM_DO(bram_do), .X_ADDR(x_addr), .X_DATA(x_data)
  );

  typedef struct {
    logic [15:0] y;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t               q[$];
  exp_t               mon_e;
  logic [4:0]         wlog[$];
  logic signed [15:0] wref[N];
  logic signed [15:0] xmem[N];
  logic [15:0]        bram[N];
  int                 checks = 0;
  int                 errors = 0;
  int                 cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory models: both update their data outputs on the falling edge.
  always @(negedge clk) begin
    if (bram_en) begin
      if (bram_we) begin
        bram[bram_addr] <= bram_di;
        wlog.push_back(bram_addr);
      end
      bram_do <= bram[bram_addr];
    end
    x_data <= xmem[x_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got Y=%0h want no DONE", y);
      end else begin
        mon_e = q.pop_front();
        check("y", 32'(y), 32'(mon_e.y));
        check("ovf", 32'(ovf), 32'(mon_e.ovf));
        check("done_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  function automatic void model(output logic [15:0] ey, output logic eo);
    longint s;
    longint sh;
    s = 0;
    for (int i = 0; i < N; i++) s += longint'(wref[i]) * longint'(xmem[i]);
    sh = s >>> 8;
    if (sh > 32767) begin
      ey = 16'h7FFF; eo = 1'b1;
    end else if (sh < -32768) begin
      ey = 16'h8000; eo = 1'b1;
    end else begin
      ey = 16'(sh); eo = 1'b0;
    end
  endfunction

  function automatic logic [15:0] rnd_small();
    int v;
    v = int'($urandom_range(0, 1023)) - 512;
    return 16'(v);
  endfunction

  task automatic run(input logic [15:0] ey, input logic eo);
    @(posedge clk); #1;
    start = 1'b1;
    q.push_back('{y: ey, ovf: eo, cyc: cyc + N + 2});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_model();
    logic [15:0] ey;
    logic        eo;
    model(ey, eo);
    run(ey, eo);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("drain_pending", 32'(q.size()), 32'd0);
  endtask

  task automatic load_weights(input bit toggle, input bit with_start);
    wlog.delete();
    @(posedge clk); #1;
    load_start = 1'b1;
    start      = with_start;
    @(posedge clk); #1;
    load_start = 1'b0;
    start      = 1'b0;
    check("ld_ready", 32'(ld_ready), 32'd1);
    check("busy_load", 32'(busy), 32'd1);
    for (int i = 0; i < N; i++) begin
      if (toggle && (i % 2 == 1)) begin
        ld_valid = 1'b0;
        ld_data  = 16'($urandom);
        @(posedge clk); #1;
      end
      ld_valid = 1'b1;
      ld_data  = wref[i];
      @(posedge clk); #1;
    end
    ld_valid = 1'b0;
    check("load_done", 32'(load_done), 32'd1);
    check("ld_ready_after", 32'(ld_ready), 32'd0);
    check("write_count", 32'(wlog.size()), 32'(N));
    if (wlog.size() == N)
      for (int i = 0; i < N; i++) check("write_addr", 32'(wlog[i]), 32'(i));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] ey;
    logic        eo;
    int          k;
    rst = 1'b1; start = 1'b0; load_start = 1'b0; ld_valid = 1'b0; ld_data = '0;
    for (int i = 0; i < N; i++) begin
      bram[i] = '0; xmem[i] = '0; wref[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_en", 32'(bram_en), 32'd0);
    check("rst_we", 32'(bram_we), 32'd0);
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_addr", 32'(bram_addr), 32'd0);
    check("rst_xaddr", 32'(x_addr), 32'd0);
    rst = 1'b0;

    // Directed saturation / sign cases.
    for (int i = 0; i < N; i++) begin wref[i] = 16'sh0100; xmem[i] = 16'sh0100; end
    load_weights(1'b0, 1'b0);
    run(16'h1C00, 1'b0); drain();
    for (int i = 0; i < N; i++) wref[i] = 16'shFF00;
    load_weights(1'b0, 1'b0);
    run(16'hE400, 1'b0); drain();
    for (int i = 0; i < N; i++) begin wref[i] = 16'sh7FFF; xmem[i] = 16'sh7FFF; end
    load_weights(1'b0, 1'b0);
    run(16'h7FFF, 1'b1); drain();
    for (int i = 0; i < N; i++) wref[i] = 16'sh8000;
    load_weights(1'b0, 1'b0);
    run(16'h8000, 1'b1); drain();

    // Stalled load, then read individual weights back with one-hot activations.
    for (int i = 0; i < N; i++) wref[i] = 16'($urandom);
    load_weights(1'b1, 1'b0);
    for (int t = 0; t < 4; t++) begin
      int idx;
      idx = int'($urandom_range(0, N - 1));
      if (t == 0) idx = 0;
      if (t == 1) idx = N - 1;
      for (int i = 0; i < N; i++) xmem[i] = (i == idx) ? 16'sh0100 : 16'sh0000;
      run(wref[idx], 1'b0); drain();
    end

    // START together with LOAD_START: load wins, no DONE expected.
    for (int i = 0; i < N; i++) begin wref[i] = rnd_small(); xmem[i] = rnd_small(); end
    load_weights(1'b0, 1'b1);
    run_model(); drain();

    // START / LOAD_START while busy are ignored.
    for (int i = 0; i < N; i++) xmem[i] = rnd_small();
    run_model();
    repeat (5) @(posedge clk);
    #1; start = 1'b1; load_start = 1'b1;
    @(posedge clk); #1; start = 1'b0; load_start = 1'b0;
    drain();
    repeat (40) @(posedge clk);
    #1;
    check("busy_idle_after_ignored", 32'(busy), 32'd0);

    // Reset in the middle of a run.
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    #1; rst = 1'b1; q.delete();
    @(posedge clk); #1; rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_en", 32'(bram_en), 32'd0);
    check("midrst_y", 32'(y), 32'd0);
    check("midrst_ovf", 32'(ovf), 32'd0);
    for (int i = 0; i < N; i++) xmem[i] = rnd_small();
    run_model(); drain();

    // Back-to-back: new START issued during the DONE cycle.
    for (int i = 0; i < N; i++) xmem[i] = rnd_small();
    run_model();
    k = 0;
    while (!done && k < 100) begin @(posedge clk); #1; k++; end
    check("b2b_first_done_seen", 32'(done), 32'd1);
    for (int i = 0; i < N; i++) xmem[i] = rnd_small();
    model(ey, eo);
    start = 1'b1;
    q.push_back('{y: ey, ovf: eo, cyc: cyc + N + 2});
    @(posedge clk); #1; start = 1'b0;
    drain();

    // Random weights and activations, mixing in-range and saturating magnitudes.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) wref[i] = (r < 2) ? rnd_small() : 16'($urandom);
      load_weights(r[0], 1'b0);
      for (int i = 0; i < N; i++) xmem[i] = (r < 3) ? rnd_small() : 16'($urandom);
      run_model(); drain();
    end

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_mac_controller.md
# neuron_mac_controller

Sequences one 28-entry signed 16-bit weight BRAM (negedge-read, EN/WE, 5-bit ADDR) through a full dot product against an activation memory of the same shape. Produces a saturated Q8.8 neuron pre-activation with a start/done handshake. Also owns the sequential weight-load path into the BRAM, so the BRAM has a single master. Sits between the layer scheduler (START/DONE) and one weight BRAM plus its activation source.

## Interface
Parameters:
- N, 28, number of weights/activations per neuron
- AW, 5, address width
- DW, 16, data width (signed Q8.8)
- ACCW, 40, accumulator width (signed)
- FRAC, 8, fractional bits removed from accumulator on output

Ports:
- CLK  in  1  rising-edge clock; the attached memories update DO on falling edge
- RST  in  1  synchronous, active-high reset
- START  in  1  begin dot product; sampled in IDLE only
- LOAD_START  in  1  begin weight load; sampled in IDLE only
- LD_VALID  in  1  LD_DATA valid this cycle
- LD_DATA  in  DW  weight word to write
- LD_READY  out  1  high in LOAD state
- LOAD_DONE  out  1  one-cycle pulse after entry N-1 written
- BUSY  out  1  high in any state other than IDLE
- DONE  out  1  one-cycle pulse, Y/OVF valid
- Y  out  DW  signed saturated result, held until next DONE
- OVF  out  1  Y was clamped; held with Y
- BRAM_ADDR  out  AW  weight BRAM address
- BRAM_DI  out  DW  weight BRAM write data (= LD_DATA)
- BRAM_EN  out  1  weight BRAM enable
- BRAM_WE  out  1  weight BRAM write enable
- BRAM_DO  in  DW  weight BRAM read data, valid at the rising edge after its address
- X_ADDR  out  AW  activation memory address
- X_DATA  in  DW  activation data, same timing as BRAM_DO

## Operation
- States: IDLE, LOAD, RUN, FINISH.
- IDLE: BRAM_EN=0, BRAM_WE=0.
  - LOAD_START -> LOAD, cnt=0.
  - Else START -> RUN, cnt=0, acc=0.
  - Both asserted in the same cycle: LOAD wins and START is dropped.
- LOAD:
  - BRAM_ADDR=cnt, BRAM_EN=BRAM_WE=LD_VALID.
  - On each edge with LD_VALID=1, cnt increments.
  - Write of cnt=N-1 -> IDLE with LOAD_DONE pulse.
  - LD_VALID=0 stalls the load with no write.
- RUN:
  - BRAM_ADDR=X_ADDR=cnt, BRAM_EN=1, BRAM_WE=0.
  - cnt increments each cycle, 0..N-1.
  - A one-bit pending flag follows the issue by one cycle.
  - On each edge with pending=1: acc <= acc + sext(BRAM_DO*X_DATA), where the product is a 32-bit signed value.
  - After issuing N-1 the controller stops issuing (BRAM_EN=0) and waits one cycle for the final accumulate, then -> FINISH.
- FINISH:
  - s = acc >>> FRAC (arithmetic shift).
  - Y = clamp(s, -2^(DW-1), 2^(DW-1)-1).
  - OVF = (s != Y).
  - Registers Y/OVF, pulses DONE, -> IDLE.
- START or LOAD_START while BUSY is ignored.
- Addresses never exceed N-1; cnt does not wrap.

## Timing
- Reset values: state=IDLE, cnt=0, acc=0, Y=0, OVF=0, DONE=0, LOAD_DONE=0, BUSY=0, LD_READY=0, BRAM_EN=0, BRAM_WE=0, BRAM_ADDR=0, X_ADDR=0.
- Read latency: address presented after rising edge k, data consumed at edge k+1, because the memories update on the intervening falling edge.
- Run latency, with START sampled at edge E0:
  - Addresses 0..N-1 are presented after edges E0..E(N-1).
  - The final accumulate occurs at E(N).
  - DONE is high during the cycle after E(N+1), i.e. N+1 cycles after START (29 for N=28).
- Back-to-back runs: START may be re-asserted in the cycle DONE is high. It is sampled in IDLE on the following edge.
- Load latency: N cycles with LD_VALID held high. LOAD_DONE is high the cycle after the last write.
- Reset mid-operation:
  - Forces IDLE and the reset values above on the next edge; no DONE or LOAD_DONE is generated.
  - A partially loaded weight set keeps the words already written.
- All outputs are registered, except that BRAM_DI is LD_DATA passed through and BRAM_EN/BRAM_WE in LOAD are gated by LD_VALID.

## Test plan
- Load all weights 0x0100, activations all 0x0100, START → DONE exactly 29 cycles after START, Y=0x1C00 (28.0), OVF=0.
- Weights 0xFF00 (-1.0), activations 0x0100 → Y=0xE400 (-28.0), OVF=0; weights 0x7FFF, activations 0x7FFF → Y=0x7FFF, OVF=1; weights 0x8000, activations 0x7FFF → Y=0x8000, OVF=1.
- Load with LD_VALID toggling every other cycle → writes occur only on valid cycles, addresses 0..27 in order, LOAD_DONE after the 28th write; read back via a run with activations set to a one-hot 0x0100 at index i → Y equals weight i.
- START and LOAD_START asserted together → LOAD entered, no run, no DONE; START pulsed while BUSY → ignored, single DONE only.
- RST asserted at cycle 10 of a run → next cycle BUSY=0, BRAM_EN=0, Y=0; a subsequent full run produces the correct result with no stale accumulation.
- Back-to-back: START re-asserted during DONE cycle with new activations → second DONE 29 cycles later with the correct independent result.
